// File: rtl/multiplier.sv
// 16x16 signed multiplier: radix-4 Booth recoding, carry-save reduction tree, prefix final adder.
// Build option MUL_PIPE_EN registers answer (1-cycle latency, synchronous active-high rst).
module multiplier (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [31:0] answer,
  input  logic               clk,
  input  logic               rst
);

  // 3:2 compressor across a full row; returns {carry << 1, sum}, carry out of bit 31 dropped.
  function automatic logic [63:0] csa(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    logic [31:0] s;
    logic [31:0] c;
    s = x ^ y ^ z;
    c = (x & y) | (x & z) | (y & z);
    return {c[30:0], 1'b0, s};
  endfunction

  // Kogge-Stone parallel-prefix adder, modulo 2^32.
  function automatic logic [31:0] ks_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] h;
    logic [31:0] gn;
    logic [31:0] pn;
    g = x & y;
    p = x ^ y;
    h = p;
    for (int k = 0; k < 5; k++) begin
      gn = g;
      pn = p;
      for (int j = (1 << k); j < 32; j++) begin
        gn[j] = g[j] | (p[j] & g[j - (1 << k)]);
        pn[j] = p[j] & p[j - (1 << k)];
      end
      g = gn;
      p = pn;
    end
    return h ^ {g[30:0], 1'b0};
  endfunction

  // Implicit 0 below b[0]; the top triplet is b[15:13], so no extra sign bits are needed.
  logic [16:0] bx;
  logic [16:0] a_one;
  logic [16:0] a_two;
  logic [31:0] pp [9];

  assign bx    = {b, 1'b0};
  assign a_one = {a[15], a};
  assign a_two = {a, 1'b0};

  // pp[0..7] are Booth rows; pp[8] collects the +1 corrections for negated rows.
  always_comb begin
    logic [2:0]  trip;
    logic        sel_one;
    logic        sel_two;
    logic        neg;
    logic [16:0] row;
    pp[8] = '0;
    for (int i = 0; i < 8; i++) begin
      trip    = bx[2*i +: 3];
      sel_one = 1'b0;
      sel_two = 1'b0;
      neg     = 1'b0;
      unique case (trip)
        3'b001, 3'b010: sel_one = 1'b1;
        3'b011:         sel_two = 1'b1;
        3'b100: begin
          sel_two = 1'b1;
          neg     = 1'b1;
        end
        3'b101, 3'b110: begin
          sel_one = 1'b1;
          neg     = 1'b1;
        end
        default: ;
      endcase
      row = sel_two ? a_two : (sel_one ? a_one : 17'd0);
      if (neg) begin
        row = ~row;
      end
      pp[i]        = {{15{row[16]}}, row} << (2 * i);
      pp[8][2*i]   = neg;
    end
  end

  // Reduction: 9 -> 6 -> 4 -> 3 -> 2 rows.
  logic [63:0] l1_0, l1_1, l1_2;
  logic [63:0] l2_0, l2_1;
  logic [63:0] l3_0;
  logic [63:0] l4_0;
  logic [31:0] product;

  assign l1_0 = csa(pp[0], pp[1], pp[2]);
  assign l1_1 = csa(pp[3], pp[4], pp[5]);
  assign l1_2 = csa(pp[6], pp[7], pp[8]);

  assign l2_0 = csa(l1_0[31:0], l1_0[63:32], l1_1[31:0]);
  assign l2_1 = csa(l1_1[63:32], l1_2[31:0], l1_2[63:32]);

  assign l3_0 = csa(l2_0[31:0], l2_0[63:32], l2_1[31:0]);

  assign l4_0 = csa(l3_0[31:0], l3_0[63:32], l2_1[63:32]);

  assign product = ks_add(l4_0[31:0], l4_0[63:32]);

`ifdef MUL_PIPE_EN
  logic [31:0] answer_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      answer_q <= 32'h0000_0000;
    end else begin
      answer_q <= product;
    end
  end

  assign answer = answer_q;
`else
  // clk and rst exist only for port compatibility with the pipelined build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign answer = product;
`endif

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: randomized operands against a plain-arithmetic model,
// plus hand-computed literal expectations. Handles both the default and MUL_PIPE_EN builds.
`timescale 1ns/1ps
module tb_multiplier;

  logic signed [15:0] a;
  logic signed [15:0] b;
  logic signed [31:0] answer;
  logic               clk;
  logic               rst;

  int                 checks;
  int                 errors;
  logic               check_en;
  logic               lit_valid;
  logic signed [31:0] lit_exp;
  string              lit_name;

  multiplier dut (
    .a      (a),
    .b      (b),
    .answer (answer),
    .clk    (clk),
    .rst    (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [31:0] model(input logic signed [15:0] x,
                                               input logic signed [15:0] y);
    logic signed [31:0] xe;
    logic signed [31:0] ye;
    xe = 32'(x);
    ye = 32'(y);
    return xe * ye;
  endfunction

`ifdef MUL_PIPE_EN
  logic signed [31:0] exp_q;
  always @(posedge clk) exp_q <= rst ? 32'sd0 : model(a, b);
`endif

  // Single compare process: model every cycle, literal when one is posted.
  always @(negedge clk) begin
    logic signed [31:0] expv;
    if (check_en) begin
`ifdef MUL_PIPE_EN
      expv = exp_q;
`else
      expv = model(a, b);
`endif
      checks++;
      if (answer !== expv) begin
        errors++;
        $display("FAIL model a=%0d b=%0d answer=%h expected=%h", a, b, answer, expv);
      end
      if (lit_valid) begin
        checks++;
        if (answer !== lit_exp) begin
          errors++;
          $display("FAIL %s answer=%h expected=%h", lit_name, answer, lit_exp);
        end
      end
    end
  end

  task automatic apply(input logic signed [15:0] x, input logic signed [15:0] y,
                       input logic r, input logic lv, input logic signed [31:0] le,
                       input string nm);
    @(posedge clk);
    #1;
    a         = x;
    b         = y;
    rst       = r;
    lit_valid = lv;
    lit_exp   = le;
    lit_name  = nm;
    check_en  = 1'b1;
  endtask

  logic signed [15:0] corners [5];

  initial begin
    logic signed [15:0] x;
    logic signed [15:0] y;
    checks    = 0;
    errors    = 0;
    check_en  = 1'b0;
    lit_valid = 1'b0;
    lit_exp   = '0;
    lit_name  = "";
    rst       = 1'b1;
    a         = '0;
    b         = '0;
    corners   = '{16'sd0, 16'sd1, -16'sd1, 16'sh7FFF, 16'sh8000};

`ifdef MUL_PIPE_EN
    apply(16'sd5, 16'sd5, 1'b1, 1'b1, 32'sd0, "reset_cycle1");
    apply(16'sd100, -16'sd7, 1'b0, 1'b1, 32'sd0, "reset_cycle2");
    apply(16'sd7, 16'sd7, 1'b0, 1'b1, -32'sd700, "first_after_reset");
    apply(16'sd9, 16'sd9, 1'b1, 1'b1, 32'sd49, "before_mid_reset");
    apply(16'sd3, 16'sd3, 1'b0, 1'b1, 32'sd0, "mid_stream_reset");
    apply(16'sd0, 16'sd0, 1'b0, 1'b1, 32'sd9, "after_mid_reset");
`else
    apply(16'sd3, -16'sd5, 1'b1, 1'b1, 32'hFFFF_FFF1, "3x-5_rst_ignored");
    apply(16'sh8000, 16'sh8000, 1'b0, 1'b1, 32'h4000_0000, "min_x_min");
    apply(16'sh8000, 16'sh7FFF, 1'b0, 1'b1, -32'sd1073709056, "min_x_max");
    apply(16'sh8000, 16'sd1, 1'b1, 1'b1, 32'hFFFF_8000, "min_x_one");
    apply(16'sd0, -16'sd1234, 1'b0, 1'b1, 32'sd0, "zero_x_neg");
    apply(16'sd1234, 16'sd0, 1'b0, 1'b1, 32'sd0, "pos_x_zero");
    apply(-16'sd1, -16'sd1, 1'b0, 1'b1, 32'sd1, "neg1_x_neg1");
    apply(16'sh7FFF, 16'sh7FFF, 1'b0, 1'b1, 32'sd1073676289, "max_x_max");
    apply(16'sd123, -16'sd456, 1'b0, 1'b1, -32'sd56088, "123_x_-456");
    apply(-16'sd300, -16'sd200, 1'b0, 1'b1, 32'sd60000, "neg_x_neg");
    for (int k = 0; k < 16; k++) begin
      apply(16'(32'sd1 << k), -16'sd1, 1'b0, 1'b1,
            (k == 15) ? 32'sd32768 : -(32'sd1 <<< k), "walking_one");
    end
`endif

    for (int n = 0; n < 150; n++) begin
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      apply(x, y, 1'b0, 1'b0, 32'sd0, "random");
      @(negedge clk);
      #1;
      $display("case %0d: a=%0d b=%0d answer=%0d", n, a, b, answer);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
